// File: rtl/writeback_unit.sv
// Register-file write side: formats retired results, queues them in a small FIFO,
// drains one write per cycle and serves rs1/rs2 forwarding from not-yet-landed writes.

module writeback_fwd #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic [4:0]                  rs_i,
    input  logic [DEPTH-1:0]            ent_vld_i,   // index 0 = youngest
    input  logic [DEPTH-1:0][4:0]       ent_addr_i,
    input  logic [DEPTH-1:0][XLEN-1:0]  ent_data_i,
    input  logic                        rf_we_i,
    input  logic [4:0]                  rf_waddr_i,
    input  logic [XLEN-1:0]             rf_wdata_i,
    output logic                        hit_o,
    output logic [XLEN-1:0]             data_o
);
    // Lowest priority first so that younger matches overwrite older ones.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        if (rs_i != 5'd0) begin
            if (rf_we_i && rf_waddr_i == rs_i) begin
                hit_o  = 1'b1;
                data_o = rf_wdata_i;
            end
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (ent_vld_i[k] && ent_addr_i[k] == rs_i) begin
                    hit_o  = 1'b1;
                    data_o = ent_data_i[k];
                end
            end
        end
    end
endmodule

module writeback_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic                     in_RegWrite,
    input  logic                     in_MemtoReg,
    input  logic [2:0]               in_funct3,
    input  logic [XLEN-1:0]          in_alu,
    input  logic [XLEN-1:0]          in_mem_data,
    input  logic                     wb_stall,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    output logic                     fwd1_hit,
    output logic [XLEN-1:0]          fwd1_data,
    output logic                     fwd2_hit,
    output logic [XLEN-1:0]          fwd2_data,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW:0]     FULL_CNT = (PW + 1)'(DEPTH);

    logic [DEPTH-1:0][4:0]      addr_q;
    logic [DEPTH-1:0][XLEN-1:0] data_q;
    logic [PW-1:0]              wptr_q, rptr_q;
    logic [PW:0]                count_q, count_d;
    logic                       rf_we_q;
    logic [4:0]                 rf_waddr_q;
    logic [XLEN-1:0]            rf_wdata_q;

    logic                       push, pop;
    logic [XLEN-1:0]            fmt_data;

    function automatic logic [XLEN-1:0] fmt(input logic m2r, input logic [2:0] f3,
                                            input logic [XLEN-1:0] alu,
                                            input logic [XLEN-1:0] mem);
        logic [7:0]  b;
        logic [15:0] h;
        b = mem[{alu[1:0], 3'b000} +: 8];
        h = alu[1] ? mem[31:16] : mem[15:0];
        if (!m2r) return alu;
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return mem;
        endcase
    endfunction

    // Ready depends only on registered occupancy, so a full FIFO refuses even while popping.
    assign in_ready = !rst && (count_q != FULL_CNT);
    assign push     = in_valid && in_ready && in_RegWrite && (in_rd != 5'd0);
    assign pop      = (count_q != '0) && !wb_stall;
    assign fmt_data = fmt(in_MemtoReg, in_funct3, in_alu, in_mem_data);

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) begin
                rptr_q     <= rptr_q + 1'b1;
                rf_we_q    <= 1'b1;
                rf_waddr_q <= addr_q[rptr_q];
                rf_wdata_q <= data_q[rptr_q];
            end else begin
                rf_we_q    <= 1'b0;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_q[wptr_q] <= in_rd;
            data_q[wptr_q] <= fmt_data;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign pending  = count_q;

    logic [DEPTH-1:0]            ord_vld;
    logic [DEPTH-1:0][4:0]       ord_addr;
    logic [DEPTH-1:0][XLEN-1:0]  ord_data;

    always_comb begin
        ord_vld  = '0;
        ord_addr = '0;
        ord_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ord_vld[k]  = (PW + 1)'(k) < count_q;
            ord_addr[k] = addr_q[wptr_q - PW'(k + 1)];
            ord_data[k] = data_q[wptr_q - PW'(k + 1)];
        end
    end

    logic [1:0][4:0]       rs_vec;
    logic [1:0]            hit_vec;
    logic [1:0][XLEN-1:0]  fdata_vec;

    assign rs_vec = {rs2, rs1};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_fwd
            writeback_fwd #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fwd (
                .rs_i       (rs_vec[g]),
                .ent_vld_i  (ord_vld),
                .ent_addr_i (ord_addr),
                .ent_data_i (ord_data),
                .rf_we_i    (rf_we_q),
                .rf_waddr_i (rf_waddr_q),
                .rf_wdata_i (rf_wdata_q),
                .hit_o      (hit_vec[g]),
                .data_o     (fdata_vec[g])
            );
        end
    endgenerate

    assign fwd1_hit  = hit_vec[0];
    assign fwd1_data = fdata_vec[0];
    assign fwd2_hit  = hit_vec[1];
    assign fwd2_data = fdata_vec[1];
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset, formatting, discard, full/drain order,
// forwarding priority and mid-operation reset.

module tb_writeback_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic        in_RegWrite = 1'b0;
    logic        in_MemtoReg = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_alu = '0;
    logic [31:0] in_mem_data = '0;
    logic        wb_stall = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
    logic [2:0]  pending;

    int checks = 0;
    int errors = 0;

    writeback_unit #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg), .in_funct3(in_funct3),
        .in_alu(in_alu), .in_mem_data(in_mem_data), .wb_stall(wb_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rs1(rs1), .rs2(rs2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [4:0] rd, input logic rw, input logic m2r,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] mem);
        in_rd = rd; in_RegWrite = rw; in_MemtoReg = m2r;
        in_funct3 = f3; in_alu = alu; in_mem_data = mem;
    endtask

    // Single-cycle transfer; callers only use it when in_ready is known to be high.
    task automatic push(input logic [4:0] rd, input logic rw, input logic m2r,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] mem);
        setup(rd, rw, m2r, f3, alu, mem);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] exp);
        push(5'd10, 1'b1, 1'b1, f3, {30'h0, off}, 32'h8001_80FF);
        @(posedge clk); #1;
        chk({tag, "_we"}, rf_we, 1);
        chk(tag, rf_wdata, exp);
    endtask

    task automatic basic_write(input string tag);
        push(5'd5, 1'b1, 1'b0, 3'b010, 32'hDEAD_BEEF, 32'h0);
        chk({tag, "_pend1"}, pending, 1);
        chk({tag, "_we_early"}, rf_we, 0);
        @(posedge clk); #1;
        chk({tag, "_we"}, rf_we, 1);
        chk({tag, "_waddr"}, rf_waddr, 5);
        chk({tag, "_wdata"}, rf_wdata, 32'hDEAD_BEEF);
        chk({tag, "_pend0"}, pending, 0);
        @(posedge clk); #1;
        chk({tag, "_we_off"}, rf_we, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwe;
        int nw;
        int first_c, last_c;
        logic [4:0]  wa [5];
        logic [31:0] wd [5];
        logic        xfer;

        // Reset
        #1;
        chk("rst_ready", in_ready, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_pend", pending, 0);
        rst = 1'b0; #1;
        chk("ready_after_rst", in_ready, 1);
        basic_write("t1");

        // Load formatting of 0x800180FF
        load_chk("lb1",  3'b000, 2'd1, 32'hFFFF_FF80);
        load_chk("lbu1", 3'b100, 2'd1, 32'h0000_0080);
        load_chk("lh2",  3'b001, 2'd2, 32'hFFFF_8001);
        load_chk("lhu2", 3'b101, 2'd2, 32'h0000_8001);
        load_chk("f111", 3'b111, 2'd0, 32'h8001_80FF);
        load_chk("lb0",  3'b000, 2'd0, 32'hFFFF_FFFF);
        load_chk("lhu0", 3'b101, 2'd0, 32'h0000_80FF);
        @(posedge clk); #1;

        // Discarded transfers
        nwe = 0;
        push(5'd0, 1'b1, 1'b0, 3'b0, 32'h1234, 32'h0);
        chk("drop_rd0_pend", pending, 0);
        if (rf_we) nwe++;
        push(5'd3, 1'b0, 1'b0, 3'b0, 32'h5678, 32'h0);
        chk("drop_rw0_pend", pending, 0);
        if (rf_we) nwe++;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (rf_we) nwe++;
        end
        chk("drop_no_we", nwe, 0);

        // Fill while stalled, then drain in order
        wb_stall = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 1'b1, 1'b0, 3'b0, 32'h100 + i, 32'h0);
        chk("full_pend", pending, 4);
        chk("full_ready", in_ready, 0);
        setup(5'd5, 1'b1, 1'b0, 3'b0, 32'h105, 32'h0);
        in_valid = 1'b1;
        wb_stall = 1'b0;
        #1;
        chk("full_pop_ready", in_ready, 0);
        nw = 0; first_c = 0; last_c = 0;
        for (int c = 0; c < 10; c++) begin
            xfer = in_valid && in_ready;
            @(posedge clk); #1;
            if (xfer) in_valid = 1'b0;
            if (rf_we) begin
                if (nw < 5) begin
                    wa[nw] = rf_waddr;
                    wd[nw] = rf_wdata;
                end
                if (nw == 0) first_c = c;
                last_c = c;
                nw++;
            end
        end
        chk("drain_count", nw, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drain_addr%0d", i), wa[i], i + 1);
            chk($sformatf("drain_data%0d", i), wd[i], 32'h101 + i);
        end
        chk("drain_consec", last_c - first_c, 4);
        in_valid = 1'b0;

        // Forwarding
        wb_stall = 1'b1;
        push(5'd7, 1'b1, 1'b0, 3'b0, 32'h11, 32'h0);
        push(5'd7, 1'b1, 1'b0, 3'b0, 32'h22, 32'h0);
        rs1 = 5'd7; rs2 = 5'd0; #1;
        chk("fwd1_hit", fwd1_hit, 1);
        chk("fwd1_young", fwd1_data, 32'h22);
        chk("fwd2_rs0", fwd2_hit, 0);
        chk("fwd2_rs0_data", fwd2_data, 0);
        rs2 = 5'd9; #1;
        chk("fwd2_miss", fwd2_hit, 0);
        wb_stall = 1'b0;
        @(posedge clk); #1;
        chk("fwd_mix_pend", pending, 1);
        chk("fwd_mix_hit", fwd1_hit, 1);
        chk("fwd_mix_data", fwd1_data, 32'h22);
        @(posedge clk); #1;
        chk("fwd_rf_we", rf_we, 1);
        chk("fwd_rf_hit", fwd1_hit, 1);
        chk("fwd_rf_data", fwd1_data, 32'h22);
        @(posedge clk); #1;
        chk("fwd_gone_hit", fwd1_hit, 0);
        chk("fwd_gone_data", fwd1_data, 0);
        rs1 = 5'd0; rs2 = 5'd0;

        // Reset with entries pending
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) push(5'(20 + i), 1'b1, 1'b0, 3'b0, 32'hA0 + i, 32'h0);
        chk("mid_pend3", pending, 3);
        rst = 1'b1; #1;
        chk("mid_rst_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wb_stall = 1'b0;
        chk("mid_pend0", pending, 0);
        chk("mid_we0", rf_we, 0);
        nwe = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (rf_we) nwe++;
        end
        chk("mid_no_we", nwe, 0);
        basic_write("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
